// File: rtl/req_chan_rcvr.sv
// req_chan_rcvr: request-channel receiver with command FIFO, flush/drain
// FSM and sticky unsupported-atomic error capture.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   a_valid/a_ready   request handshake from master
//   a_id, a_addr      request ID and address
//   a_atop            atomic opcode (only zero supported)
//   cmd_valid/ready   head-of-queue handshake to slave core
//   cmd_id, cmd_addr  head entry fields
//   flush             pulse requesting drain; flush_done pulses on completion
//   atop_err, err_sid, err_id   sticky atomic error and its capture
//   q_count           queue occupancy
module req_chan_rcvr #(
   parameter int         RQR_AW   = 2,
   parameter logic [1:0] RQR_S_ID = 2'b00
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [3:0]        a_id,
   input  logic [31:0]       a_addr,
   input  logic [5:0]        a_atop,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [3:0]        cmd_id,
   output logic [31:0]       cmd_addr,
   input  logic              flush,
   output logic              flush_done,
   output logic              atop_err,
   output logic [1:0]        err_sid,
   output logic [3:0]        err_id,
   output logic [RQR_AW:0]   q_count
);

   localparam int DEPTH = 2 ** RQR_AW;
   localparam logic [RQR_AW:0] FULL = (RQR_AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [35:0]       mem [DEPTH];
   logic [RQR_AW-1:0] wr_ptr;
   logic [RQR_AW-1:0] rd_ptr;
   logic [RQR_AW:0]   count_nxt;

   logic accept;
   logic push;
   logic pop;
   logic atop_hit;

   // Ready comes from registered state only, so no path from a_* to a_ready.
   assign a_ready   = (state == RUN) && (q_count != FULL);
   assign cmd_valid = (q_count != '0);
   assign cmd_id    = mem[rd_ptr][35:32];
   assign cmd_addr  = mem[rd_ptr][31:0];
   assign err_sid   = RQR_S_ID;
   assign flush_done = (state == DONE);

   assign accept   = a_valid && a_ready;
   assign push     = accept && (a_atop == 6'd0);
   assign atop_hit = accept && (a_atop != 6'd0);
   assign pop      = cmd_valid && cmd_ready;

   always_comb begin
      count_nxt = q_count;
      unique case ({push, pop})
         2'b10:   count_nxt = q_count + 1'b1;
         2'b01:   count_nxt = q_count - 1'b1;
         default: count_nxt = q_count;
      endcase
   end

   // Drain completion looks at the post-pop occupancy so the last pop
   // and the DONE transition share a cycle.
   always_comb begin
      state_nxt = state;
      unique case (state)
         RUN:     if (flush) state_nxt = DRAIN;
         DRAIN:   if (count_nxt == '0) state_nxt = DONE;
         DONE:    state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         q_count  <= '0;
         atop_err <= 1'b0;
         err_id   <= 4'd0;
      end else begin
         state   <= state_nxt;
         q_count <= count_nxt;
         if (push) wr_ptr <= wr_ptr + RQR_AW'(1);
         if (pop)  rd_ptr <= rd_ptr + RQR_AW'(1);
         if (atop_hit) begin
            atop_err <= 1'b1;
            if (!atop_err) err_id <= a_id;
         end
      end
   end

   // Storage needs no reset; occupancy gates its visibility.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {a_id, a_addr};
   end

endmodule

// File: tb/tb_req_chan_rcvr.sv
// tb_req_chan_rcvr: directed scoreboard bench for req_chan_rcvr.
// Expected commands are queued on accept and compared on pop.
module tb_req_chan_rcvr;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_valid;
   logic        a_ready;
   logic [3:0]  a_id;
   logic [31:0] a_addr;
   logic [5:0]  a_atop;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_id;
   logic [31:0] cmd_addr;
   logic        flush;
   logic        flush_done;
   logic        atop_err;
   logic [1:0]  err_sid;
   logic [3:0]  err_id;
   logic [2:0]  q_count;

   int n_cmp = 0;
   int n_err = 0;

   logic [35:0] sb [$];
   int          ms = 0;
   logic        m_err = 1'b0;
   logic [3:0]  m_eid = 4'd0;
   int          pops = 0;

   always #5 clk = ~clk;

   req_chan_rcvr #(.RQR_AW(2), .RQR_S_ID(2'b10)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready),
      .a_id(a_id), .a_addr(a_addr), .a_atop(a_atop),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_id(cmd_id), .cmd_addr(cmd_addr),
      .flush(flush), .flush_done(flush_done),
      .atop_err(atop_err), .err_sid(err_sid), .err_id(err_id),
      .q_count(q_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check outputs against the model for the current cycle, then step
   // the model and the clock. Called just after a falling edge.
   task automatic tick();
      logic rdy;
      logic pp;
      rdy = (ms == 0) && (sb.size() < 4);
      pp  = (sb.size() != 0) && cmd_ready;
      chk("a_ready", 64'(a_ready), 64'(rdy));
      chk("cmd_valid", 64'(cmd_valid), 64'(sb.size() != 0));
      chk("q_count", 64'(q_count), 64'(sb.size()));
      chk("flush_done", 64'(flush_done), 64'(ms == 2));
      chk("atop_err", 64'(atop_err), 64'(m_err));
      chk("err_sid", 64'(err_sid), 64'(2'b10));
      if (m_err) chk("err_id", 64'(err_id), 64'(m_eid));
      if (pp) begin
         chk("cmd_id", 64'(cmd_id), 64'(sb[0][35:32]));
         chk("cmd_addr", 64'(cmd_addr), 64'(sb[0][31:0]));
         void'(sb.pop_front());
         pops++;
      end
      if (a_valid && rdy) begin
         if (a_atop == 6'd0) sb.push_back({a_id, a_addr});
         else begin
            if (!m_err) m_eid = a_id;
            m_err = 1'b1;
         end
      end
      case (ms)
         0: if (flush) ms = 1;
         1: if (sb.size() == 0) ms = 2;
         default: ms = 0;
      endcase
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic req(input logic [3:0] id, input logic [31:0] ad,
                      input logic [5:0] at);
      a_valid = 1'b1;
      a_id    = id;
      a_addr  = ad;
      a_atop  = at;
   endtask

   initial begin
      rst_n = 1'b0;
      a_valid = 1'b0; a_id = '0; a_addr = '0; a_atop = '0;
      cmd_ready = 1'b0; flush = 1'b0;
      #3;
      chk("rst_a_ready", 64'(a_ready), 64'd1);
      chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
      chk("rst_q_count", 64'(q_count), 64'd0);
      chk("rst_flush_done", 64'(flush_done), 64'd0);
      chk("rst_atop_err", 64'(atop_err), 64'd0);
      chk("rst_err_id", 64'(err_id), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // single request with immediate consumption
      req(4'h5, 32'h0000_1000, 6'd0);
      cmd_ready = 1'b1;
      tick();
      a_valid = 1'b0;
      chk("single_valid", 64'(cmd_valid), 64'd1);
      chk("single_id", 64'(cmd_id), 64'h5);
      tick();
      chk("single_empty", 64'(q_count), 64'd0);

      // fill to depth, fifth request held until space frees
      cmd_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req(4'(i), 32'h100 + 32'(i), 6'd0);
         tick();
      end
      chk("fill_count", 64'(q_count), 64'd4);
      chk("fill_ready", 64'(a_ready), 64'd0);
      req(4'hE, 32'hDEAD_BEEF, 6'd0);
      tick();
      cmd_ready = 1'b1;
      tick();
      chk("fill_reopen", 64'(a_ready), 64'd1);
      tick();
      a_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("fill_drained", 64'(q_count), 64'd0);

      // concurrent push/pop at count 2 across pointer wrap
      cmd_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req(4'(8 + i), 32'h2000 + 32'(i), 6'd0);
         tick();
      end
      cmd_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         req(4'(i + 2), 32'h3000 + 32'(i), 6'd0);
         tick();
         chk("conc_count", 64'(q_count), 64'd2);
      end
      a_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();

      // unsupported atomics
      cmd_ready = 1'b0;
      req(4'h9, 32'h4000, 6'h01);
      tick();
      chk("atop_first", 64'(err_id), 64'h9);
      req(4'hA, 32'h4004, 6'h20);
      tick();
      a_valid = 1'b0;
      chk("atop_sticky_id", 64'(err_id), 64'h9);
      chk("atop_not_queued", 64'(q_count), 64'd0);

      // flush with three entries, flush coincident with the third accept
      for (int i = 0; i < 3; i++) begin
         req(4'(i + 4), 32'h5000 + 32'(i), 6'd0);
         flush = (i == 2);
         tick();
      end
      a_valid = 1'b0;
      flush = 1'b0;
      pops = 0;
      for (int i = 0; i < 6; i++) begin
         cmd_ready = i[0];
         req(4'hF, 32'hF000, 6'd0);
         flush = (i == 1);
         tick();
      end
      a_valid = 1'b0;
      flush = 1'b0;
      cmd_ready = 1'b0;
      chk("flush_pops", 64'(pops), 64'd3);
      chk("flush_done_pulse", 64'(flush_done), 64'd1);
      tick();
      chk("flush_done_clear", 64'(flush_done), 64'd0);
      chk("flush_reopen", 64'(a_ready), 64'd1);

      // flush on empty queue
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      chk("eflush_done", 64'(flush_done), 64'd1);
      tick();

      // reset during drain with two queued
      for (int i = 0; i < 2; i++) begin
         req(4'(i + 1), 32'h6000 + 32'(i), 6'd0);
         tick();
      end
      a_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rrst_cmd_valid", 64'(cmd_valid), 64'd0);
      chk("rrst_q_count", 64'(q_count), 64'd0);
      chk("rrst_a_ready", 64'(a_ready), 64'd1);
      chk("rrst_atop_err", 64'(atop_err), 64'd0);
      sb.delete();
      ms = 0;
      m_err = 1'b0;
      m_eid = 4'd0;
      @(negedge clk);
      rst_n = 1'b1;
      cmd_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      req(4'h7, 32'h7000, 6'd0);
      tick();
      a_valid = 1'b0;
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/req_chan_rcvr.md
REQ_CHAN_RCVR -- requirements
Module: req_chan_rcvr

Interface
REQ-001 Parameter RQR_AW, default 2, SHALL set queue address width; queue depth SHALL be 2**RQR_AW entries.
REQ-002 Parameter RQR_S_ID, default 2'b00, SHALL give the slave identifier reported on err_sid.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 a_valid  input  1  request-channel valid from the master.
REQ-006 a_ready  output  1  request-channel ready to the master.
REQ-007 a_id  input  4  request ID {master ID[3:2], sequence[1:0]}.
REQ-008 a_addr  input  32  request address.
REQ-009 a_atop  input  6  atomic opcode; only 6'b000000 is supported.
REQ-010 cmd_valid  output  1  queued command available to the slave core.
REQ-011 cmd_ready  input  1  slave core consumes the head command.
REQ-012 cmd_id  output  4  head-entry ID.
REQ-013 cmd_addr  output  32  head-entry address.
REQ-014 flush  input  1  one-cycle pulse requesting drain mode.
REQ-015 flush_done  output  1  one-cycle pulse when the drain completes.
REQ-016 atop_err  output  1  sticky flag for an unsupported atomic request.
REQ-017 err_sid  output  2  equals RQR_S_ID.
REQ-018 err_id  output  4  a_id of the first request that set atop_err.
REQ-019 q_count  output  RQR_AW+1  number of valid queue entries.

Function
REQ-020 The block SHALL contain a FIFO of {id[3:0], addr[31:0]} entries with registered read/write pointers and an occupancy counter.
REQ-021 Accept SHALL occur when a_valid & a_ready at a clock edge.
REQ-022 a_ready SHALL equal (state == RUN) & (q_count != depth), decoded from registers only.
REQ-023 An accepted request with a_atop == 0 SHALL be written to the queue tail.
REQ-024 An accepted request with a_atop != 0 SHALL NOT be queued; it SHALL set atop_err. err_id SHALL load a_id only if atop_err was 0.
REQ-025 cmd_valid SHALL equal (q_count != 0); cmd_id and cmd_addr SHALL show the head entry.
REQ-026 Pop SHALL occur when cmd_valid & cmd_ready; cmd_ready while empty SHALL have no effect.
REQ-027 Latency SHALL be 1 cycle: a request accepted at edge N SHALL give cmd_valid=1 after edge N. There SHALL be no combinational bypass from a_* to cmd_*.
REQ-028 On a simultaneous push and pop, q_count SHALL be unchanged and both pointers SHALL advance.
REQ-029 Pointers SHALL wrap modulo depth; q_count SHALL never exceed depth or drop below 0.
REQ-030 The FSM SHALL have states RUN, DRAIN and DONE.
REQ-031 RUN -> DRAIN on flush=1.
REQ-032 DRAIN -> DONE when q_count==0, including any entry popped in that same cycle (post-pop count 0).
REQ-033 DONE -> RUN unconditionally after 1 cycle.
REQ-034 flush asserted in DRAIN or DONE SHALL be ignored.
REQ-035 In DRAIN and DONE, a_ready SHALL be 0 and pops SHALL continue normally.
REQ-036 flush_done SHALL be 1 exactly while in DONE.
REQ-037 flush together with an accept in the same RUN cycle SHALL queue that request, which is then drained.
REQ-038 flush with an empty queue SHALL give RUN -> DRAIN -> DONE -> RUN, with flush_done high on the 3rd cycle.
REQ-039 atop_err SHALL clear only on reset.

Reset
REQ-040 On rst_n=0, with no clock required, the block SHALL force:
- state=RUN
- pointers=0, q_count=0
- a_ready=1, cmd_valid=0
- flush_done=0
- atop_err=0, err_id=0
REQ-041 Reset mid-operation SHALL discard all queued entries; no cmd_valid SHALL appear after release until a new accept.

Verification
REQ-042 Single request: a_valid=1, a_id=4'h5, a_addr=32'h0000_1000, atop=0, cmd_ready=1 -> cmd_valid=1 on the next cycle with cmd_id=5 and cmd_addr=0x1000, popped, q_count back to 0.
REQ-043 Fill: 4 back-to-back accepts with cmd_ready=0 -> q_count=4 and a_ready=0; a 5th a_valid is held. Then a single pop -> a_ready=1 and entries exit in order.
REQ-044 Concurrent: q_count=2, push and pop in the same cycle -> q_count stays 2 and order is preserved across a pointer wrap.
REQ-045 Atomic: request with a_atop=6'h01, a_id=4'h9 -> not queued, atop_err=1, err_id=9; a later atop request with a_id=4'hA leaves err_id=9.
REQ-046 Flush: 3 entries queued, flush pulse, one pop per 2 cycles -> a_ready=0 throughout; flush_done pulses once, 1 cycle after the 3rd pop; then a_ready=1.
REQ-047 Reset: rst_n asserted with 2 entries queued during DRAIN -> immediately cmd_valid=0, q_count=0, a_ready=1, state RUN.
